// File: rtl/cpu_step_controller_pkg.sv
// Shared types and defaults for the CPU step controller.
// State encodings are fixed because debug probes decode them.
package cpu_step_controller_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StStep = 2'b01,
        StRun  = 2'b10
    } state_e;

    localparam int unsigned DbSamplesDefault = 4;
    localparam int unsigned CntWDefault      = 16;

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board-side bundle of the step controller: divider tick, raw buttons and CPU-facing status.
interface cpu_step_controller_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             tick;
    logic             btn_step;
    logic             btn_mode;
    logic             btn_halt;
    logic             cpu_en;
    logic             mode_run;
    logic             halted;
    logic [CNT_W-1:0] step_count;

    modport master (
        output tick, btn_step, btn_mode, btn_halt,
        input  cpu_en, mode_run, halted, step_count
    );

    modport slave (
        input  tick, btn_step, btn_mode, btn_halt,
        output cpu_en, mode_run, halted, step_count
    );

endinterface

// File: rtl/cpu_step_controller_btn_debounce.sv
// One button: 2-FF synchroniser, tick-sampled debounce and a one-cycle registered press pulse.
module cpu_step_controller_btn_debounce #(
    parameter int unsigned DB_SAMPLES = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = $clog2(DB_SAMPLES + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick) begin
            if (sync2_q != level_q) begin
                // The DB_SAMPLES-th disagreeing sample flips the level.
                if (cnt_q == CntW'(DB_SAMPLES - 1)) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    press_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Turns the divider tick and debounced buttons into the CPU clock-enable:
// halt, single-step (one cycle per step press) and free-run (one cycle per tick).
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int unsigned DB_SAMPLES = DbSamplesDefault,
    parameter int unsigned CNT_W      = CntWDefault
) (
    input  logic                   clk_in,
    input  logic                   reset,
    cpu_step_controller_if.slave   bus
);

    logic step_p, mode_p, halt_p;

    cpu_step_controller_btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_step (
        .clk_in (clk_in),
        .reset  (reset),
        .tick   (bus.tick),
        .btn    (bus.btn_step),
        .press  (step_p)
    );

    cpu_step_controller_btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_mode (
        .clk_in (clk_in),
        .reset  (reset),
        .tick   (bus.tick),
        .btn    (bus.btn_mode),
        .press  (mode_p)
    );

    cpu_step_controller_btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_halt (
        .clk_in (clk_in),
        .reset  (reset),
        .tick   (bus.tick),
        .btn    (bus.btn_halt),
        .press  (halt_p)
    );

    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             mode_run_q, halted_q;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (halt_p) begin
                    state_d = StHalt;
                end else if (mode_p) begin
                    state_d = StRun;
                end else if (step_p) begin
                    state_d = StStep;
                end
            end
            StStep:  state_d = StHalt;
            StRun:   if (halt_p || mode_p) state_d = StHalt;
            default: state_d = StHalt;
        endcase
        // A tick in the cycle RUN is being left must not leak a CPU cycle.
        cpu_en_d = (state_q == StStep) ||
                   ((state_q == StRun) && (state_d == StRun) && bus.tick);
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= StHalt;
            cpu_en_q   <= 1'b0;
            mode_run_q <= 1'b0;
            halted_q   <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cpu_en_q   <= cpu_en_d;
            mode_run_q <= (state_d == StRun);
            halted_q   <= (state_d == StHalt);
            if (cpu_en_q) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.mode_run   = mode_run_q;
    assign bus.halted     = halted_q;
    assign bus.step_count = count_q;

endmodule
